// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and the launch-sequencer state type for the UART
//            transmit path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    HOLDOFF   = 2'd0,
    IDLE      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  localparam int c_CLKS_PER_BIT = 10417;
  localparam int c_FRAME_BITS   = 10;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock circular-buffer FIFO with a separate occupancy
//            counter and a combinational head-of-queue read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_n,
  input  logic                     i_Wr_En,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Rd_En,
  output logic [WIDTH-1:0]         o_Rd_Data,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Full/empty come from the registered count, so a same-cycle pop never
  // makes room for a write.
  assign o_Full    = (r_count == c_FULL);
  assign o_Empty   = (r_count == '0);
  assign o_Count   = r_count;
  assign o_Rd_Data = r_mem[r_rd_ptr];
  assign w_wr      = i_Wr_En && !o_Full;
  assign w_rd      = i_Rd_En && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// ============================================================================
// Module   : uart_tx_queue
// Brief    : Byte queue plus launch sequencer feeding a UART transmitter, with
//            a post-reset hold-off covering a possibly unfinished frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
  parameter int HOLDOFF_CLKS = c_FRAME_BITS * CLKS_PER_BIT + 2
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Wr_En,
  input  logic [7:0]             i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Overflow,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy
);

  localparam int                c_HO_W    = (HOLDOFF_CLKS > 1) ? $clog2(HOLDOFF_CLKS) : 1;
  localparam logic [c_HO_W-1:0] c_HO_LAST = c_HO_W'(HOLDOFF_CLKS - 1);

  tx_state_t          r_state;
  logic [c_HO_W-1:0]  r_ho_cnt;
  logic               r_tx_dv;
  logic [7:0]         r_tx_byte;
  logic               r_overflow;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [7:0]         w_head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd_En   (w_pop),
    .o_Rd_Data (w_head),
    .o_Full    (w_full),
    .o_Empty   (w_empty),
    .o_Count   (o_Count)
  );

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:      w_pop = !w_empty;
      WAIT_DONE: w_pop = i_Tx_Done && !w_empty;
      default:   w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= HOLDOFF;
      r_ho_cnt   <= '0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_Wr_En && w_full;
      r_tx_dv    <= 1'b0;
      case (r_state)
        HOLDOFF: begin
          if (r_ho_cnt == c_HO_LAST) begin
            r_ho_cnt <= '0;
            r_state  <= IDLE;
          end else begin
            r_ho_cnt <= r_ho_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (!w_empty) begin
            r_tx_byte <= w_head;
            r_tx_dv   <= 1'b1;
            r_state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Relaunch straight from the done pulse keeps the line gap-free.
          if (i_Tx_Done) begin
            if (!w_empty) begin
              r_tx_byte <= w_head;
              r_tx_dv   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= HOLDOFF;
      endcase
    end
  end

  assign o_Full     = w_full;
  assign o_Empty    = w_empty;
  assign o_Overflow = r_overflow;
  assign o_Tx_DV    = r_tx_dv;
  assign o_Tx_Byte  = r_tx_byte;
  assign o_Busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
// ============================================================================
// Module   : tb_uart_tx_queue
// Brief    : Directed bench for uart_tx_queue driving a behavioural UART
//            transmitter (no reset) and a serial-line receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_queue;

  localparam int c_DEPTH = 4;
  localparam int c_CPB   = 4;
  localparam int c_HOLD  = 42;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       full, empty, overflow, tx_dv, busy;
  logic [2:0] count;
  logic [7:0] tx_byte;

  // Transmitter model state
  logic       tx_done   = 1'b0;
  logic       tx_serial = 1'b1;
  logic       tx_active = 1'b0;
  logic [9:0] tx_frame  = '0;
  int         tx_bit    = 0;
  int         tx_clk    = 0;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH        (c_DEPTH),
    .CLKS_PER_BIT (c_CPB),
    .HOLDOFF_CLKS (c_HOLD)
  ) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Wr_En    (wr_en),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (overflow),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Done  (tx_done),
    .o_Busy     (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Start bit from the DV-sampling edge, CPB clocks per bit, done after stop.
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (!tx_active) begin
      if (tx_dv) begin
        tx_active <= 1'b1;
        tx_frame  <= {1'b1, tx_byte, 1'b0};
        tx_serial <= 1'b0;
        tx_bit    <= 0;
        tx_clk    <= 0;
      end
    end else if (tx_clk == c_CPB - 1) begin
      tx_clk <= 0;
      if (tx_bit == 9) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        tx_serial <= 1'b1;
      end else begin
        tx_bit    <= tx_bit + 1;
        tx_serial <= tx_frame[tx_bit + 1];
      end
    end else begin
      tx_clk <= tx_clk + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } launch_t;

  launch_t    launch_q[$];
  logic [9:0] rx_q[$];
  logic       prev_dv = 1'b0;
  int         ovf_cnt = 0;
  logic       rx_busy = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_n    = 0;
  logic [9:0] rx_sh   = '0;

  always @(negedge clk) begin
    if (tx_dv) begin
      launch_q.push_back('{cyc, tx_byte});
      check_val("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
    end
    if (overflow) ovf_cnt++;
    prev_dv = tx_dv;
  end

  // Receiver samples mid-bit; bit k of the captured frame is the k-th bit on the line.
  always @(negedge clk) begin
    if (!rx_busy && rx_prev && !tx_serial) begin
      rx_busy = 1'b1;
      rx_n    = 0;
    end
    if (rx_busy) begin
      if (rx_n % c_CPB == c_CPB / 2) rx_sh[rx_n / c_CPB] = tx_serial;
      if (rx_n == 9 * c_CPB + c_CPB / 2) begin
        rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end else begin
        rx_n++;
      end
    end
    rx_prev = tx_serial;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_byte = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int maxc, input string tag);
    int k = 0;
    while (launch_q.size() < n && k < maxc) begin
      step();
      k++;
    end
    check_val({tag, "_launch_count"}, launch_q.size(), n);
  endtask

  task automatic wait_frames(input int n, input int maxc, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < maxc) begin
      step();
      k++;
    end
    check_val({tag, "_frame_count"}, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k = 0;
    while ((busy || !empty) && k < maxc) begin
      step();
      k++;
    end
    check_val({tag, "_idle_busy_empty"}, {30'd0, busy, empty}, 32'd1);
  endtask

  task automatic check_launches(input string tag, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < launch_q.size()) check_val({tag, "_byte"}, launch_q[i].b, first + 8'(i));
    end
  endtask

  int rel;
  int t0;
  int busy_low;
  int k;

  initial begin
    // Reset values
    repeat (3) step();
    check_val("rst_tx_dv",    tx_dv,    0);
    check_val("rst_tx_byte",  tx_byte,  0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_full",     full,     0);
    check_val("rst_empty",    empty,    1);
    check_val("rst_count",    count,    0);
    check_val("rst_busy",     busy,     1);

    // 1: hold-off after reset release, byte written on edge 1
    rst_n   = 1'b1;
    rel     = cyc;
    write_byte(8'hA5);
    busy_low = 0;
    k        = 0;
    while (launch_q.size() == 0 && k < 100) begin
      if (!busy && (cyc - rel) < c_HOLD) busy_low++;
      step();
      k++;
    end
    check_val("t1_holdoff_busy", busy_low, 0);
    check_val("t1_launch_seen", launch_q.size(), 1);
    if (launch_q.size() > 0) begin
      check_val("t1_launch_edge", launch_q[0].cyc - rel, c_HOLD + 1);
      check_val("t1_byte", launch_q[0].b, 8'hA5);
    end
    wait_frames(1, 100, "t1");
    if (rx_q.size() > 0) check_val("t1_frame", rx_q[0], {1'b1, 8'hA5, 1'b0});
    wait_idle(100, "t1");

    // 2: back-to-back launches
    launch_q.delete();
    rx_q.delete();
    t0      = cyc;
    wr_en   = 1'b1;
    wr_byte = 8'h01; step();
    wr_byte = 8'h02; step();
    wr_byte = 8'h03; step();
    wr_en   = 1'b0;
    wait_launches(3, 200, "t2");
    if (launch_q.size() >= 3) begin
      check_val("t2_latency", launch_q[0].cyc - t0, 2);
      check_val("t2_gap01", launch_q[1].cyc - launch_q[0].cyc, c_HOLD);
      check_val("t2_gap12", launch_q[2].cyc - launch_q[1].cyc, c_HOLD);
    end
    check_launches("t2", 8'h01, 3);
    wait_frames(3, 200, "t2");
    for (int i = 0; i < rx_q.size(); i++) begin
      check_val("t2_frame", rx_q[i], {1'b1, 8'(i + 1), 1'b0});
    end
    wait_idle(100, "t2");

    // 3: overflow while a frame is in flight
    launch_q.delete();
    rx_q.delete();
    ovf_cnt = 0;
    write_byte(8'h30);
    wait_launches(1, 10, "t3_first");
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_byte = 8'h31 + 8'(i);
      step();
      if (i == 3) begin
        check_val("t3_full", full, 1);
        check_val("t3_count_full", count, 4);
        check_val("t3_no_ovf_yet", overflow, 0);
      end
      if (i == 4) begin
        check_val("t3_overflow", overflow, 1);
        check_val("t3_count_kept", count, 4);
      end
    end
    wr_en = 1'b0;
    step();
    check_val("t3_overflow_pulse_end", overflow, 0);
    wait_launches(5, 400, "t3");
    check_launches("t3", 8'h30, 5);
    check_val("t3_overflow_count", ovf_cnt, 1);
    wait_idle(100, "t3");

    // 4: write coinciding with the done-triggered pop
    launch_q.delete();
    write_byte(8'h40);
    wait_launches(1, 10, "t4_first");
    write_byte(8'h41);
    write_byte(8'h42);
    check_val("t4_count_before", count, 2);
    k = 0;
    while (!tx_done && k < 100) begin
      step();
      k++;
    end
    check_val("t4_done_seen", tx_done, 1);
    write_byte(8'h43);
    check_val("t4_count_after", count, 2);
    check_val("t4_relaunch_dv", tx_dv, 1);
    wait_launches(4, 300, "t4");
    check_launches("t4", 8'h40, 4);
    wait_idle(100, "t4");

    // 5: reset during the second data bit with three bytes queued
    launch_q.delete();
    write_byte(8'h50);
    wait_launches(1, 10, "t5_first");
    write_byte(8'h51);
    write_byte(8'h52);
    write_byte(8'h53);
    check_val("t5_count_queued", count, 3);
    repeat (7) step();
    check_val("t5_in_data_bit2", tx_bit, 2);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_tx_dv",    tx_dv,    0);
    check_val("t5_rst_tx_byte",  tx_byte,  0);
    check_val("t5_rst_overflow", overflow, 0);
    check_val("t5_rst_full",     full,     0);
    check_val("t5_rst_empty",    empty,    1);
    check_val("t5_rst_count",    count,    0);
    check_val("t5_rst_busy",     busy,     1);
    repeat (2) step();
    launch_q.delete();
    rst_n = 1'b1;
    rel   = cyc;
    write_byte(8'h60);
    wait_launches(1, 100, "t5");
    if (launch_q.size() > 0) begin
      check_val("t5_launch_edge", launch_q[0].cyc - rel, c_HOLD + 1);
      check_val("t5_byte", launch_q[0].b, 8'h60);
    end
    rx_q.delete();
    wait_frames(1, 100, "t5");
    if (rx_q.size() > 0) check_val("t5_frame", rx_q[0], {1'b1, 8'h60, 1'b0});
    wait_idle(100, "t5");
    check_val("t5_no_stale_launch", launch_q.size(), 1);

    // 6: stream ten bytes through the four-entry queue
    launch_q.delete();
    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (full && k < 200) begin
        step();
        k++;
      end
      write_byte(8'h10 + 8'(i));
    end
    wait_launches(10, 600, "t6");
    check_launches("t6", 8'h10, 10);
    check_val("t6_no_overflow", ovf_cnt, 0);
    wait_idle(100, "t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=stalled expected=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
